// File: rtl/stepper_scan_seq.sv
// stepper_scan_seq: stepper-motor scan sequencer (lead travel, dwell/step scan, return travel).
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   asynchronous active-high reset
//   start     in   one-cycle request to begin a sequence (honoured only in IDLE)
//   abort     in   stop motion and return to IDLE (priority over everything)
//   ENA       out  driver enable, high in LEAD/STEP/RETURN
//   DIR       out  driver direction, 1 = lead/return, 0 = scan
//   PUL       out  step pulse train
//   busy      out  high in every state except IDLE
//   acq       out  acquisition window, high in DWELL
//   step_idx  out  current scan position index
//   done      out  one-cycle pulse at sequence completion
// Build option: define STEPPER_CONTINUOUS_EN to loop DONE straight back into LEAD.
module stepper_scan_seq #(
    parameter int PUL_DIV      = 8,
    parameter int LEAD_PULSES  = 3200,
    parameter int STEP_PULSES  = 320,
    parameter int DWELL_CYCLES = 2500,
    parameter int NUM_STEPS    = 20,
    parameter int CNT_W        = 16,
    parameter int IDX_W        = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    output logic             ENA,
    output logic             DIR,
    output logic             PUL,
    output logic             busy,
    output logic             acq,
    output logic [IDX_W-1:0] step_idx,
    output logic             done
);
    typedef enum logic [2:0] {IDLE, LEAD, DWELL, STEP, RETURN, DONE} state_t;

    localparam logic [CNT_W-1:0] PH_TOP    = CNT_W'(2 * PUL_DIV - 1);
    localparam logic [CNT_W-1:0] PH_HALF   = CNT_W'(PUL_DIV);
    localparam logic [CNT_W-1:0] LEAD_TOP  = CNT_W'(LEAD_PULSES - 1);
    localparam logic [CNT_W-1:0] STEP_TOP  = CNT_W'(STEP_PULSES - 1);
    localparam logic [CNT_W-1:0] DWELL_TOP = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_STEPS);
`ifdef STEPPER_CONTINUOUS_EN
    localparam state_t AFTER_DONE = LEAD;
`else
    localparam state_t AFTER_DONE = IDLE;
`endif

    state_t           state, state_n;
    logic [CNT_W-1:0] ph, ph_n, cnt, cnt_n;
    logic [IDX_W-1:0] idx_n;
    logic             motion, motion_n, wrap, fin, dir_n;

    assign motion   = state == LEAD || state == STEP || state == RETURN;
    assign motion_n = state_n == LEAD || state_n == STEP || state_n == RETURN;
    assign wrap     = ph == PH_TOP;
    // cnt counts completed pulses in motion states and elapsed cycles in DWELL
    assign fin      = wrap && cnt == (state == STEP ? STEP_TOP : LEAD_TOP);
    assign dir_n    = (state_n == LEAD || state_n == RETURN) ? 1'b1 :
                      (state_n == STEP || state_n == IDLE) ? 1'b0 : DIR;

    always_comb begin
        state_n = state;
        idx_n   = step_idx;
        case (state)
            IDLE:    state_n = start ? LEAD : IDLE;
            LEAD:    state_n = fin ? DWELL : LEAD;
            DWELL:   if (cnt == DWELL_TOP) state_n = (step_idx < LAST_IDX) ? STEP : RETURN;
            STEP:    if (fin) begin
                         state_n = DWELL;
                         idx_n   = step_idx + IDX_W'(1);
                     end
            RETURN:  state_n = fin ? DONE : RETURN;
            DONE:    state_n = AFTER_DONE;
            default: state_n = IDLE;
        endcase
        if (abort && state != IDLE) begin
            state_n = IDLE;
            idx_n   = step_idx;
        end
        if (state_n == LEAD && state != LEAD) idx_n = '0;
        ph_n  = '0;
        cnt_n = '0;
        if (state_n == state && motion) begin
            ph_n  = wrap ? '0 : ph + CNT_W'(1);
            cnt_n = wrap ? cnt + CNT_W'(1) : cnt;
        end else if (state_n == state && state == DWELL) begin
            cnt_n = cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ph       <= '0;
            cnt      <= '0;
            step_idx <= '0;
            ENA      <= 1'b0;
            DIR      <= 1'b0;
            PUL      <= 1'b0;
            busy     <= 1'b0;
            acq      <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            ph       <= ph_n;
            cnt      <= cnt_n;
            step_idx <= idx_n;
            // outputs are registered from next-state values so they align with the state register
            ENA      <= motion_n;
            DIR      <= dir_n;
            PUL      <= motion_n && ph_n >= PH_HALF;
            busy     <= state_n != IDLE;
            acq      <= state_n == DWELL;
            done     <= state_n == DONE;
        end
    end
endmodule

// File: tb/tb_stepper_scan_seq.sv
// tb_stepper_scan_seq: directed self-checking bench for stepper_scan_seq with a small configuration.
module tb_stepper_scan_seq;
    logic       clk = 1'b0;
    logic       rst, start, abort;
    logic       ENA, DIR, PUL, busy, acq, done;
    logic [4:0] step_idx;
    int         errors = 0;
    int         checks = 0;

    logic e_a [0:79];
    logic d_a [0:79];
    logic p_a [0:79];
    logic a_a [0:79];
    logic b_a [0:79];
    logic [4:0] i_a [0:79];
    logic [4:0] dq [$];
    int edges, lead_edges, busy_cnt, done_cnt, done_at;
    logic prev_pul, prev_acq;
    logic [4:0] acq_v, ena_v;

    stepper_scan_seq #(
        .PUL_DIV(2), .LEAD_PULSES(4), .STEP_PULSES(2), .DWELL_CYCLES(5),
        .NUM_STEPS(3), .CNT_W(16), .IDX_W(5)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .ENA(ENA), .DIR(DIR), .PUL(PUL), .busy(busy), .acq(acq),
        .step_idx(step_idx), .done(done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        repeat (2) tick();
        check("reset_outs", {ENA, DIR, PUL, busy, acq, done}, 0);
        check("reset_idx", step_idx, 0);
        rst = 1'b0;
        tick();
        check("idle_outs", {ENA, DIR, PUL, busy, acq, done}, 0);

        // full run, recording cycles 1..78 after the start edge
        start = 1'b1;
        tick();
        start = 1'b0;
        edges = 0; lead_edges = 0; busy_cnt = 0; done_cnt = 0; done_at = 0;
        prev_pul = 1'b0; prev_acq = 1'b0;
        for (int n = 1; n <= 78; n++) begin
            e_a[n] = ENA; d_a[n] = DIR; p_a[n] = PUL; a_a[n] = acq; b_a[n] = busy; i_a[n] = step_idx;
            if (PUL && !prev_pul) begin
                edges++;
                if (n <= 16) lead_edges++;
            end
            if (acq && !prev_acq) dq.push_back(step_idx);
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                done_at = n;
            end
            prev_pul = PUL;
            prev_acq = acq;
            if (n < 78) tick();
        end
        check("lead_c1", {e_a[1], d_a[1], p_a[1], b_a[1]}, 4'b1101);
        check("lead_pul_c2", p_a[2], 0);
        check("lead_pul_c3", p_a[3], 1);
        check("lead_edges", lead_edges, 4);
        acq_v = '0; ena_v = '0;
        for (int k = 0; k < 5; k++) begin
            acq_v[k] = a_a[17 + k];
            ena_v[k] = e_a[17 + k];
        end
        check("dwell1_acq", acq_v, 5'b11111);
        check("dwell1_ena", ena_v, 5'b00000);
        check("dwell1_idx", i_a[17], 0);
        check("step1_c22", {a_a[22], e_a[22], d_a[22]}, 3'b010);
        check("pul_edges", edges, 14);
        check("dwell_count", dq.size(), 4);
        for (int k = 0; k < dq.size() && k < 4; k++) check("dwell_idx", dq[k], k);
        check("done_count", done_cnt, 1);
        check("done_cycle", done_at, 77);
`ifdef STEPPER_CONTINUOUS_EN
        check("busy_cycles", busy_cnt, 78);
        check("cont_relead", {b_a[78], e_a[78], d_a[78], i_a[78]}, {3'b111, 5'd0});
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("cont_abort", {busy, ENA}, 0);
        tick();
        check("cont_hold_idle", busy, 0);
`else
        check("busy_cycles", busy_cnt, 77);
        check("end_idle", {b_a[78], e_a[78]}, 0);
`endif

        // abort during the second STEP (cycles 35..42)
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (36) tick();
        check("step2_state", {ENA, DIR, step_idx}, {2'b10, 5'd1});
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_outs", {ENA, PUL, acq, busy, done}, 0);
        check("abort_idx_hold", step_idx, 1);
        done_cnt = 0; busy_cnt = 0;
        for (int n = 0; n < 20; n++) begin
            if (done) done_cnt++;
            if (busy) busy_cnt++;
            tick();
        end
        check("abort_no_done", done_cnt, 0);
        check("abort_stays_idle", busy_cnt, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_lead", {ENA, DIR, busy, step_idx}, {3'b111, 5'd0});

        // start while busy (in DWELL) is ignored
        repeat (17) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_busy_dwell", {acq, ENA}, 2'b10);
        repeat (3) tick();
        check("start_busy_step", {ENA, DIR, acq, step_idx}, {3'b100, 5'd0});
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_step1", busy, 0);

        // start and abort together in LEAD: abort wins, start not latched
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        abort = 1'b1; start = 1'b1;
        tick();
        abort = 1'b0; start = 1'b0;
        check("abort_start_lead", {busy, ENA}, 0);
        tick();
        check("abort_start_hold", busy, 0);

        // asynchronous reset mid-DWELL (second dwell, cycles 30..34)
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (31) tick();
        check("dwell2_pre_rst", {acq, step_idx}, {1'b1, 5'd1});
        #2 rst = 1'b1;
        #1;
        check("async_rst_outs", {ENA, DIR, PUL, busy, acq, done}, 0);
        check("async_rst_idx", step_idx, 0);
        #3 rst = 1'b0;
        repeat (2) tick();
        check("post_rst_idle", {busy, ENA, done}, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("post_rst_start", {ENA, DIR, busy}, 3'b111);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
